serial_bit_tx: RTL and testbench
================================

Name: serial_bit_tx

Overview:
- Parallel-to-serial transmitter that generates the single-bit data stream sampled by the team's flop-based serial capture logic.
- Accepts a WIDTH-bit word over a valid/ready handshake and frames it as: start bit (0), data bits LSB first, optional even parity, stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between the local data source and the serial line.

Parameters:
WIDTH, 8, data word width in bits (1..32)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  word to transmit
in_valid  input  1  source has a word on in_data
in_ready  output  1  transmitter can accept a word this cycle
sd  output  1  serial data line, registered
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last stop-bit cycle

Behaviour:
- Reset, asynchronous while rst=1:
  - State=IDLE, sd=1, busy=0, done=0, in_ready=1.
  - Bit counter, cycle counter and shift register cleared.
- Reset mid-frame: the frame is abandoned immediately and sd returns to 1. No done pulse. On rst deassertion the block resumes in IDLE.
- Handshake:
  - Transfer occurs on a posedge where in_valid=1 and in_ready=1.
  - in_ready=1 only in IDLE; it is combinational from state.
  - in_data is latched into the shift register on transfer. Parity is computed as XOR of the latched word.
  - in_data changes after transfer do not affect the frame.
- States:
  - IDLE: sd=1. On transfer -> START; the cycle counter loads 0.
  - START: sd=0 for CLKS_PER_BIT cycles -> DATA, with bit index=0.
  - DATA: sd=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit WIDTH-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sd=even parity bit (XOR of the data) for CLKS_PER_BIT cycles -> STOP.
  - STOP: sd=1 for CLKS_PER_BIT cycles -> IDLE, with done=1 in the following cycle.
- Timing:
  - sd, busy and done are registered.
  - The first cycle of sd=0 is the cycle after the transfer edge.
  - Frame length = (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles.
- busy=1 in every state except IDLE.
- done is asserted for exactly one cycle, the first IDLE cycle after STOP. in_ready is also 1 in that cycle.
- Back-to-back: if in_valid is held high, the next transfer occurs on the done cycle. The next start bit begins on the following cycle, so there is no extra idle gap beyond the one IDLE cycle.
- CLKS_PER_BIT=1: each state lasts exactly one cycle. The counter compare uses CLKS_PER_BIT-1 and has no off-by-one.
- The cycle counter is $clog2(CLKS_PER_BIT)+1 bits wide and wraps to 0 at each bit boundary.
- The bit index is $clog2(WIDTH)+1 bits wide, so WIDTH values that are powers of two never overflow.
- in_valid while busy is ignored: no transfer, and the data is not latched.
- X on in_data while in_valid=0 has no effect on any output.

Test Plan:
1. Basic frame. WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0, in_data=8'hA5, one-cycle valid.
   - sd = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (LSB first) at 4 cycles each, then 1 for 4 cycles.
   - done pulses at cycle 41 after transfer; busy=1 for 40 cycles.
2. Parity. PARITY_EN=1, in_data=8'h07.
   - Parity bit=1, inserted after the data bits; frame is 44 cycles.
   - With in_data=8'h03 the parity bit=0.
3. Back-to-back. in_valid held high with 8'h01 then 8'hFF.
   - Second transfer occurs on the done cycle, with exactly one sd=1 IDLE cycle between the frames.
   - in_ready=0 throughout each frame.
4. Busy rejection. Pulse in_valid with 8'h3C mid-frame.
   - No transfer; the current frame is unchanged.
   - After done, sd stays 1 and busy=0.
5. Asynchronous reset mid-frame. Assert rst between posedges during DATA bit 3.
   - sd=1 and busy=0 immediately, no done pulse.
   - After release, a new frame with 8'h5A transmits correctly.
6. CLKS_PER_BIT=1, WIDTH=4, in_data=4'b1001.
   - sd sequence 0,1,0,0,1,1 on consecutive cycles.
   - done on cycle 7 after transfer.

Source files
------------

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: frames a WIDTH-bit word as start(0), data LSB first,
// optional even parity, stop(1), each bit held CLKS_PER_BIT cycles.
// sd/busy/done are registered from the next-state values, so the line
// reflects a state on the cycle the FSM enters it.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | line high, in_ready=1, waiting for a transfer
//   START  | driving the start bit (0)
//   DATA   | driving shift_q[0], one data bit per bit period
//   PARITY | driving the even-parity bit of the latched word
//   STOP   | driving the stop bit (1); done follows on exit
module serial_bit_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sd,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             cnt_last;
  logic             sd_d, busy_d, done_d;

  // in_ready is purely a function of state so the source sees it the same cycle
  assign in_ready = (state_q == IDLE);
  assign cnt_last = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
    end
  end

  // Next-state and datapath update; the cycle counter wraps at every bit boundary
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = START;
          cnt_d    = '0;
          idx_d    = '0;
          shift_d  = in_data;
          parity_d = ^in_data;
        end
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered line lines up with it
  always_comb begin
    sd_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   sd_d = 1'b0;
      DATA:    sd_d = shift_d[0];
      PARITY:  sd_d = parity_d;
      default: sd_d = 1'b1;
    endcase
  end

  // Registered outputs; reset drops the line back to idle-high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sd   <= sd_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: three instances cover the default framing,
// even parity, and single-cycle bits. Outputs are sampled on negedge as
// {sd,busy,done,in_ready} and compared with a frame model built from
// the bit-slot arithmetic of the frame format.
module tb_serial_bit_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1;
  logic [3:0] d2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       s0, s1, s2;
  logic       b0, b1, b2;
  logic       dn0, dn1, dn2;

  int         errors = 0;
  int         checks = 0;
  int         sel = 0;
  logic [3:0] obs;
  logic [3:0] cap [0:127];

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_plain (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .sd(s0), .busy(b0), .done(dn0));

  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .sd(s1), .busy(b1), .done(dn1));

  serial_bit_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .sd(s2), .busy(b2), .done(dn2));

  always_comb begin
    case (sel)
      1:       obs = {s1, b1, dn1, r1};
      2:       obs = {s2, b2, dn2, r2};
      default: obs = {s0, b0, dn0, r0};
    endcase
  end

  // Expected {sd,busy,done,in_ready} for cycle k after the transfer edge
  // (k=1 is the first cycle of the start bit).
  function automatic logic [3:0] exp_out(int w, int cpb, int par, logic [31:0] d, int k);
    int   len, b;
    logic p, s;
    len = (w + 2 + par) * cpb;
    if (k > len) return {1'b1, 1'b0, (k == len + 1), 1'b1};
    b = (k - 1) / cpb;
    p = 1'b0;
    for (int i = 0; i < w; i++) p ^= d[i];
    if (b == 0)                     s = 1'b0;
    else if (b <= w)                s = d[b-1];
    else if (par != 0 && b == w + 1) s = p;
    else                            s = 1'b1;
    return {s, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic set_in(input int s, input logic v, input logic [31:0] d);
    case (s)
      0:       begin v0 = v; d0 = d[7:0]; end
      1:       begin v1 = v; d1 = d[7:0]; end
      default: begin v2 = v; d2 = d[3:0]; end
    endcase
  endtask

  // Offers one word for a single cycle and records n cycles of outputs.
  task automatic send_capture(input int s, input logic [31:0] d, input int n);
    sel = s;
    @(negedge clk);
    cap[0] = obs;
    set_in(s, 1'b1, d);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap[k] = obs;
      if (k == 1) set_in(s, 1'b0, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 32'h0);
    set_in(1, 1'b0, 32'h0);
    set_in(2, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if (obs !== 4'b1001) begin
        errors++;
        $display("FAIL reset_hold dut=%0d {sd,busy,done,rdy} got %b exp 1001", s, obs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if (obs !== 4'b1001) begin
        errors++;
        $display("FAIL reset_release dut=%0d {sd,busy,done,rdy} got %b exp 1001", s, obs);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [3:0]  e;
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 32'hA5 : {24'h0, 8'($urandom)};
      send_capture(0, d, 43);
      for (int k = 0; k <= 43; k++) begin
        e = (k == 0) ? 4'b1001 : exp_out(8, 4, 0, d, k);
        checks++;
        if (cap[k] !== e) begin
          errors++;
          $display("FAIL basic d=%h cyc=%0d {sd,busy,done,rdy} got %b exp %b", d, k, cap[k], e);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [31:0] d;
    logic [3:0]  e;
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 32'h07 : (t == 1) ? 32'h03 : {24'h0, 8'($urandom)};
      send_capture(1, d, 46);
      for (int k = 0; k <= 46; k++) begin
        e = (k == 0) ? 4'b1001 : exp_out(8, 4, 1, d, k);
        checks++;
        if (cap[k] !== e) begin
          errors++;
          $display("FAIL parity d=%h cyc=%0d {sd,busy,done,rdy} got %b exp %b", d, k, cap[k], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] da, db;
    logic [3:0]  e;
    da  = 32'h01;
    db  = 32'hFF;
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, da);
    @(posedge clk);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      e = exp_out(8, 4, 0, da, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_first cyc=%0d {sd,busy,done,rdy} got %b exp %b", k, obs, e);
      end
      if (k == 41) set_in(0, 1'b1, db);
    end
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      e = exp_out(8, 4, 0, db, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_second cyc=%0d {sd,busy,done,rdy} got %b exp %b", k, obs, e);
      end
      if (k == 1) set_in(0, 1'b0, db);
    end
  endtask

  task automatic test_busy_reject();
    logic [31:0] d;
    logic [3:0]  e;
    d   = {24'h0, 8'($urandom)};
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, d);
    @(posedge clk);
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk);
      e = exp_out(8, 4, 0, d, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL busy_reject d=%h cyc=%0d {sd,busy,done,rdy} got %b exp %b", d, k, obs, e);
      end
      if (k == 1)  set_in(0, 1'b0, d);
      if (k == 12) set_in(0, 1'b1, 32'h3C);
      if (k == 13) set_in(0, 1'b0, 32'h3C);
      if (k == 43) set_in(0, 1'b0, 32'hxxxx_xxxx);
    end
    set_in(0, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [3:0]  e;
    d   = {24'h0, 8'($urandom)};
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, d);
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      e = exp_out(8, 4, 0, d, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_pre cyc=%0d {sd,busy,done,rdy} got %b exp %b", k, obs, e);
      end
      if (k == 1) set_in(0, 1'b0, d);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL areset_immediate {sd,busy,done,rdy} got %b exp 1001", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== 4'b1001) begin
        errors++;
        $display("FAIL areset_after cyc=%0d {sd,busy,done,rdy} got %b exp 1001", k, obs);
      end
    end
    send_capture(0, 32'h5A, 42);
    for (int k = 0; k <= 42; k++) begin
      e = (k == 0) ? 4'b1001 : exp_out(8, 4, 0, 32'h5A, k);
      checks++;
      if (cap[k] !== e) begin
        errors++;
        $display("FAIL areset_newframe cyc=%0d {sd,busy,done,rdy} got %b exp %b", k, cap[k], e);
      end
    end
  endtask

  task automatic test_cpb1();
    logic [31:0] d;
    logic [3:0]  e;
    for (int t = 0; t < 5; t++) begin
      d = (t == 0) ? 32'h9 : {28'h0, 4'($urandom)};
      send_capture(2, d, 9);
      for (int k = 0; k <= 9; k++) begin
        e = (k == 0) ? 4'b1001 : exp_out(4, 1, 0, d, k);
        checks++;
        if (cap[k] !== e) begin
          errors++;
          $display("FAIL cpb1 d=%h cyc=%0d {sd,busy,done,rdy} got %b exp %b", d, k, cap[k], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_busy_reject();
    test_async_reset();
    test_cpb1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
